// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared helpers for the counter family
package counter_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Legal when 2 <= modulus <= 2**width and 0 <= reset_val < modulus.
    function automatic bit counter_params_ok(input int width, input int modulus,
                                             input int reset_val);
        return (width >= 1) && (width <= 30) && (modulus >= 2) &&
               (clog2(modulus) <= width) && (reset_val >= 0) && (reset_val < modulus);
    endfunction

endpackage

// File: rtl/tff_cell.sv
// rtl/tff_cell.sv - T flip-flop bit cell with async active-high reset
module tff_cell #(
    parameter logic RST_BIT = 1'b0
) (
    input  logic t,
    input  logic clk,
    input  logic rst,
    output logic q,
    output logic qb
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= RST_BIT;
        else if (t)
            q <= ~q;
    end

    assign qb = ~q;

endmodule

// File: rtl/sync_up_counter_mod.sv
// rtl/sync_up_counter_mod.sv - synchronous presettable modulo-N up counter of T cells
module sync_up_counter_mod
    import counter_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MODULUS   = 16,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cin,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             cout,
    output logic             wrap
);

    if (!counter_params_ok(WIDTH, MODULUS, RESET_VAL)) begin : g_param_error
        $error("sync_up_counter_mod: illegal WIDTH/MODULUS/RESET_VAL");
    end

    localparam logic [WIDTH-1:0] TERM    = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_V   = WIDTH'(RESET_VAL);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] t;
    logic             wrap_next;
    logic             step;
    logic             at_term;

    assign step    = en & cin;
    assign at_term = (q == TERM);
    assign cout    = step & at_term;

    // Terminal value is matched explicitly, so non-power-of-2 moduli roll over at MODULUS-1.
    always_comb begin
        q_next    = q;
        wrap_next = 1'b0;
        if (clr) begin
            q_next = '0;
        end else if (load) begin
            q_next = ({1'b0, load_val} < MOD_EXT) ? load_val : '0;
        end else if (step) begin
            if (at_term) begin
                q_next    = '0;
                wrap_next = 1'b1;
            end else begin
                q_next = q + WIDTH'(1);
            end
        end
    end

    // Every update, including clr and load, is expressed as a toggle mask.
    assign t = q ^ q_next;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        tff_cell #(
            .RST_BIT(RST_V[i])
        ) u_cell (
            .t  (t[i]),
            .clk(clk),
            .rst(rst),
            .q  (q[i]),
            .qb (qb[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wrap <= 1'b0;
        else
            wrap <= wrap_next;
    end

endmodule

// File: tb/tb_sync_up_counter_mod.sv
// tb/tb_sync_up_counter_mod.sv - directed self-checking bench for sync_up_counter_mod
module tb_sync_up_counter_mod;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // M16 instance
    logic       a_en, a_clr, a_load;
    logic [3:0] a_load_val, a_q, a_qb;
    logic       a_cout, a_wrap;

    // M10 instance
    logic       b_en, b_clr, b_load;
    logic [3:0] b_load_val, b_q, b_qb;
    logic       b_cout, b_wrap;

    // cascaded M10 pair
    logic       c_en;
    logic [3:0] lo_q, lo_qb, hi_q, hi_qb;
    logic       lo_cout, lo_wrap, hi_cout, hi_wrap;

    sync_up_counter_mod #(.WIDTH(4), .MODULUS(16), .RESET_VAL(0)) dut16 (
        .clk(clk), .rst(rst), .en(a_en), .cin(1'b1), .clr(a_clr), .load(a_load),
        .load_val(a_load_val), .q(a_q), .qb(a_qb), .cout(a_cout), .wrap(a_wrap));

    sync_up_counter_mod #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) dut10 (
        .clk(clk), .rst(rst), .en(b_en), .cin(1'b1), .clr(b_clr), .load(b_load),
        .load_val(b_load_val), .q(b_q), .qb(b_qb), .cout(b_cout), .wrap(b_wrap));

    sync_up_counter_mod #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) dut_lo (
        .clk(clk), .rst(rst), .en(c_en), .cin(1'b1), .clr(1'b0), .load(1'b0),
        .load_val(4'd0), .q(lo_q), .qb(lo_qb), .cout(lo_cout), .wrap(lo_wrap));

    sync_up_counter_mod #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) dut_hi (
        .clk(clk), .rst(rst), .en(c_en), .cin(lo_cout), .clr(1'b0), .load(1'b0),
        .load_val(4'd0), .q(hi_q), .qb(hi_qb), .cout(hi_cout), .wrap(hi_wrap));

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int hi_wraps;

    initial begin
        rst = 1'b1;
        a_en = 0; a_clr = 0; a_load = 0; a_load_val = 0;
        b_en = 0; b_clr = 0; b_load = 0; b_load_val = 0;
        c_en = 0;

        #2;
        check("rst_q16", a_q, 0);
        check("rst_qb16", a_qb, 15);
        check("rst_wrap16", a_wrap, 0);
        tick(); tick();
        check("rst_hold_q10", b_q, 0);
        check("rst_hold_qb10", b_qb, 15);
        rst = 1'b0;

        // M16 full cycle
        a_en = 1;
        #1;
        check("m16_q_start", a_q, 0);
        check("m16_cout_start", a_cout, 0);
        for (int k = 1; k <= 16; k++) begin
            tick();
            check("m16_q", a_q, k % 16);
            check("m16_qb", a_qb, 15 - (k % 16));
            check("m16_wrap", a_wrap, (k == 16) ? 1 : 0);
            check("m16_cout", a_cout, ((k % 16) == 15) ? 1 : 0);
        end
        a_en = 0;

        // M10 counting, 25 steps
        b_en = 1;
        for (int k = 1; k <= 25; k++) begin
            tick();
            check("m10_q", b_q, k % 10);
            check("m10_wrap", b_wrap, ((k % 10) == 0) ? 1 : 0);
            check("m10_cout", b_cout, ((k % 10) == 9) ? 1 : 0);
        end

        // load, step, hold, out-of-range load
        b_load = 1; b_load_val = 7;
        tick();
        check("load7_q", b_q, 7);
        check("load7_wrap", b_wrap, 0);
        b_load = 0;
        tick();
        check("load7_step_q", b_q, 8);
        b_en = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("hold_q", b_q, 8);
        end
        b_load = 1; b_load_val = 12;
        tick();
        check("load12_q", b_q, 0);

        // clr beats load on the terminal cycle, suppresses wrap
        b_load_val = 9;
        tick();
        check("load9_q", b_q, 9);
        b_en = 1; b_load = 0;
        #1;
        check("term_cout", b_cout, 1);
        b_clr = 1; b_load = 1; b_load_val = 3;
        tick();
        check("prio_clr_q", b_q, 0);
        check("prio_clr_wrap", b_wrap, 0);
        b_clr = 0;
        tick();
        check("prio_load_q", b_q, 3);
        check("prio_load_wrap", b_wrap, 0);

        // async reset mid-count
        b_load_val = 4;
        tick();
        b_load = 0;
        tick();
        check("pre_rst_q", b_q, 5);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_q", b_q, 0);
        check("async_rst_qb", b_qb, 15);
        check("async_rst_wrap", b_wrap, 0);
        tick();
        check("rst_held_q", b_q, 0);
        rst = 1'b0;
        tick();
        check("post_rst_q", b_q, 1);
        b_en = 0;

        // cascade 00..99 twice
        hi_wraps = 0;
        c_en = 1;
        for (int k = 1; k <= 200; k++) begin
            tick();
            check("casc_lo", lo_q, k % 10);
            check("casc_hi", hi_q, (k % 100) / 10);
            if (hi_wrap) hi_wraps++;
        end
        check("casc_hi_wraps", hi_wraps, 2);
        c_en = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
